capi_put_line_buf: RTL

Put-path line buffer, directly downstream of the put-data aligner. It accepts aligned 16-byte beats, packs them into 128-byte line slots (ping-pong by default), and issues one command descriptor per closed slot to the command generator. It then serves beat reads from the command engine and frees each slot when the engine signals done.

---
 rtl/capi_put_pkg.sv | 28 ++
 rtl/capi_put_line_buf_if.sv | 47 ++++
 rtl/capi_put_line_ram.sv | 32 +++
 rtl/capi_put_line_buf.sv | 123 ++++++++++++
 4 files changed

// File: rtl/capi_put_pkg.sv
// Shared definitions for the put-path line buffer: slot states, default
// geometry and the command descriptor layout.
package capi_put_pkg;

  localparam int unsigned WIDTH_DEF = 128;
  localparam int unsigned BEATS_DEF = 8;
  localparam int unsigned SLOTS_DEF = 2;

  localparam int unsigned SLOT_W = $clog2(SLOTS_DEF);
  localparam int unsigned BEAT_W = $clog2(BEATS_DEF);
  localparam int unsigned CNT_W  = BEAT_W + 1;

  // Life cycle of one line slot.
  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_FILL = 2'd1,
    S_PEND = 2'd2,
    S_BUSY = 2'd3
  } slot_state_e;

  // Command descriptor handed to the command generator.
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [CNT_W-1:0]  beats;
    logic              e;
  } cmd_desc_t;

endpackage

// File: rtl/capi_put_line_buf_if.sv
// Bundle of the beat input, command, read and release channels of the line buffer.
interface capi_put_line_buf_if
  import capi_put_pkg::*;
#(
  parameter int unsigned width = WIDTH_DEF,
  parameter int unsigned beats = BEATS_DEF,
  parameter int unsigned slots = SLOTS_DEF
);
  localparam int unsigned SW = $clog2(slots);
  localparam int unsigned BW = $clog2(beats);

  logic            i_v;
  logic            i_r;
  logic [0:width-1] i_d;
  logic            i_e;

  logic            o_cmd_v;
  logic            o_cmd_r;
  logic [0:SW-1]   o_cmd_slot;
  logic [0:BW]     o_cmd_beats;
  logic            o_cmd_e;

  logic            i_rd_v;
  logic [0:SW-1]   i_rd_slot;
  logic [0:BW-1]   i_rd_beat;
  logic            o_rd_v;
  logic [0:width-1] o_rd_d;

  logic            i_done_v;
  logic [0:SW-1]   i_done_slot;

  logic            o_idle;
  logic            o_err;

  // Line buffer side.
  modport slave (
    input  i_v, i_d, i_e, o_cmd_r, i_rd_v, i_rd_slot, i_rd_beat, i_done_v, i_done_slot,
    output i_r, o_cmd_v, o_cmd_slot, o_cmd_beats, o_cmd_e, o_rd_v, o_rd_d, o_idle, o_err
  );

  // Aligner / command engine side.
  modport master (
    output i_v, i_d, i_e, o_cmd_r, i_rd_v, i_rd_slot, i_rd_beat, i_done_v, i_done_slot,
    input  i_r, o_cmd_v, o_cmd_slot, o_cmd_beats, o_cmd_e, o_rd_v, o_rd_d, o_idle, o_err
  );

endinterface

// File: rtl/capi_put_line_ram.sv
// Simple dual-port line storage: one write port, one registered read-first read port.
module capi_put_line_ram #(
  parameter int unsigned width = 128,
  parameter int unsigned depth = 16,
  parameter int unsigned aw    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [0:width-1] wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [0:width-1] rdata
);

  logic [0:width-1] mem [depth];

  // Write port.
  // NOTE: non-blocking writes keep the read below returning the pre-write word;
  // the array itself has no reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; only the output register is cleared on reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capi_put_line_buf.sv
// Put-path line buffer: packs aligned beats into line slots, issues one
// descriptor per closed slot in fill order, serves beat reads, frees on done.
module capi_put_line_buf
  import capi_put_pkg::*;
#(
  parameter int unsigned width = WIDTH_DEF,
  parameter int unsigned beats = BEATS_DEF,
  parameter int unsigned slots = SLOTS_DEF
) (
  input logic                clk,
  input logic                reset,
  capi_put_line_buf_if.slave bus
);

  localparam int unsigned SW = $clog2(slots);
  localparam int unsigned BW = $clog2(beats);
  localparam int unsigned CW = BW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(beats - 1);

  slot_state_e      state      [slots];
  logic [CW-1:0]    line_beats [slots];
  logic             line_e     [slots];
  logic [SW-1:0]    wslot;
  logic [SW-1:0]    cslot;
  logic [BW-1:0]    wbeat;
  logic [SW-1:0]    hold_slot;
  logic [CW-1:0]    hold_beats;
  logic             hold_e;
  logic             rd_v;
  logic             err;
  logic [0:width-1] rd_d;

  logic ready, accept, close, cmd_v, issue, done_ok, done_bad, rd_bad, all_free;

  // Idle detection across every slot.
  always_comb begin
    // NOTE: the default assignment first keeps this purely combinational (no latch).
    all_free = 1'b1;
    for (int s = 0; s < slots; s++) begin
      if (state[s] != S_FREE) all_free = 1'b0;
    end
  end

  // Ready depends only on the fill slot's registered state, never on i_v.
  assign ready    = (state[wslot] == S_FREE) || (state[wslot] == S_FILL);
  assign accept   = bus.i_v && ready;
  assign close    = accept && (bus.i_e || (wbeat == LAST_BEAT));
  assign cmd_v    = (state[cslot] == S_PEND);
  assign issue    = cmd_v && bus.o_cmd_r;
  assign done_ok  = bus.i_done_v && (state[bus.i_done_slot] == S_BUSY);
  assign done_bad = bus.i_done_v && (state[bus.i_done_slot] != S_BUSY);
  assign rd_bad   = bus.i_rd_v && (state[bus.i_rd_slot] != S_BUSY);

  assign bus.i_r         = ready;
  assign bus.o_cmd_v     = cmd_v;
  // With nothing pending the descriptor shows the last issued one.
  assign bus.o_cmd_slot  = cmd_v ? cslot             : hold_slot;
  assign bus.o_cmd_beats = cmd_v ? line_beats[cslot] : hold_beats;
  assign bus.o_cmd_e     = cmd_v ? line_e[cslot]     : hold_e;
  assign bus.o_rd_v      = rd_v;
  assign bus.o_rd_d      = rd_d;
  assign bus.o_idle      = all_free && (wbeat == '0);
  assign bus.o_err       = err;

  capi_put_line_ram #(
    .width (width),
    .depth (slots * beats),
    .aw    (SW + BW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr ({wslot, wbeat}),
    .wdata (bus.i_d),
    .re    (bus.i_rd_v),
    .raddr ({bus.i_rd_slot, bus.i_rd_beat}),
    .rdata (rd_d)
  );

  // Slot states, pointers, descriptor fields, read strobe and sticky error.
  // Close, issue and release always touch different slots (FILL, PEND, BUSY).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < slots; s++) begin
        state[s]      <= S_FREE;
        line_beats[s] <= '0;
        line_e[s]     <= 1'b0;
      end
      wslot      <= '0;
      wbeat      <= '0;
      cslot      <= '0;
      hold_slot  <= '0;
      hold_beats <= '0;
      hold_e     <= 1'b0;
      rd_v       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        if (close) begin
          state[wslot]      <= S_PEND;
          line_beats[wslot] <= CW'(wbeat) + 1'b1;
          line_e[wslot]     <= bus.i_e;
          wslot             <= wslot + 1'b1;
          wbeat             <= '0;
        end else begin
          state[wslot] <= S_FILL;
          wbeat        <= wbeat + 1'b1;
        end
      end
      if (issue) begin
        state[cslot] <= S_BUSY;
        cslot        <= cslot + 1'b1;
        hold_slot    <= cslot;
        hold_beats   <= line_beats[cslot];
        hold_e       <= line_e[cslot];
      end
      if (done_ok) state[bus.i_done_slot] <= S_FREE;
      if (done_bad || rd_bad) err <= 1'b1;
      rd_v <= bus.i_rd_v;
    end
  end

endmodule
